fpm_unit_scheduler: RTL

Functional-unit controller for the 32-bit floating-point multiplier (FPM) in the Tomasulo core. It arbitrates round-robin among NUM_RS multiply reservation stations and latches the granted operands into an internal FPM instance. It models a fixed LATENCY-cycle execute window, then holds the result on the common data bus (CDB) until the CDB arbiter acknowledges it. The unit is non-pipelined: one operation in flight at a time.

---
 rtl/fu_pkg.sv | 15 +
 rtl/fpm.sv | 61 ++++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/fpm_unit_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the floating-point functional-unit schedulers
// (multiplier and adder). Holds the scheduler state encoding, the default
// CDB tag width and the floating-point word width.
package fu_pkg;

  localparam int FLOAT_W       = 32;
  localparam int TAG_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } fu_state_e;

endpackage

// File: rtl/fpm.sv
// Combinational IEEE-754 single-precision multiplier.
// Round-to-nearest-even; subnormal inputs and results flush to signed zero;
// any NaN input or inf*0 yields the canonical quiet NaN.
// Ports:
//   a_i, b_i - operands
//   p_o      - product
module fpm (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic              sign;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       frac;
  logic              guard, sticky, rnd;
  logic [30:0]       mag;

  always_comb begin
    sign   = a_i[31] ^ b_i[31];
    a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
    a_zero = (a_i[30:23] == 8'h00);
    b_zero = (b_i[30:23] == 8'h00);

    prod  = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    exp_s = $signed({2'b00, a_i[30:23]}) + $signed({2'b00, b_i[30:23]}) - 10'sd127;

    // Significand product lies in [1,4); normalise the [2,4) case.
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    // Rounding carry propagates from fraction into exponent; a carry out of
    // exponent 254 lands exactly on the infinity encoding.
    rnd = guard & (sticky | frac[0]);
    mag = {exp_s[7:0], frac} + 31'(rnd);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p_o = 32'h7FC0_0000;
    end else if (a_inf || b_inf || exp_s >= 10'sd255) begin
      p_o = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero || exp_s <= 10'sd0) begin
      p_o = {sign, 31'd0};
    end else begin
      p_o = {sign, mag};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches req_i starting at (ptr_i + 1) mod N and
// wrapping, so the most recently served index (ptr_i) has lowest priority.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the last granted requester
//   grant_o - one-hot grant (all zero when no request)
//   idx_o   - binary index of the granted requester
//   valid_o - at least one request present
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every combinational output gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fpm_unit_scheduler.sv
// Functional-unit controller for the FP multiplier. Arbitrates round-robin
// among NUM_RS reservation stations, latches the winner's operands, charges
// LATENCY execute cycles, then holds the product on the CDB until acked.
// One operation in flight at a time.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   flush          - squash in-flight op (returns to IDLE next edge)
//   rs_req/a/b/tag - per-station request and packed operands/tags
//   rs_grant       - one-hot grant, combinational, IDLE only
//   busy           - op in EXEC or WB
//   cdb_valid/tag/value, cdb_ack - CDB result handshake
module fpm_unit_scheduler
  import fu_pkg::*;
#(
  parameter int NUM_RS  = 3,
  parameter int TAG_W   = TAG_W_DEFAULT,
  parameter int LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_RS-1:0]         rs_req,
  input  logic [NUM_RS*FLOAT_W-1:0] rs_a,
  input  logic [NUM_RS*FLOAT_W-1:0] rs_b,
  input  logic [NUM_RS*TAG_W-1:0]   rs_tag,
  output logic [NUM_RS-1:0]         rs_grant,
  output logic                      busy,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [FLOAT_W-1:0]        cdb_value,
  input  logic                      cdb_ack
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  fu_state_e          state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [FLOAT_W-1:0] cdb_value_q, cdb_value_d;
  logic [FLOAT_W-1:0] op_a_q, op_b_q;
  logic [TAG_W-1:0]   op_tag_q;

  logic [NUM_RS-1:0]  arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               grant_ok;
  logic [FLOAT_W-1:0] fpm_p;

  rr_arbiter #(.N(NUM_RS), .IDX_W(IDX_W)) u_arb (
    .req_i   (rs_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  fpm u_fpm (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (fpm_p)
  );

  // Flush suppresses a coincident grant so the station keeps its request.
  assign grant_ok  = (state_q == ST_IDLE) && arb_valid && !flush;
  assign rs_grant  = grant_ok ? arb_grant : '0;
  assign busy      = (state_q != ST_IDLE);
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          ptr_d   = arb_idx;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          cdb_value_d = fpm_p;
          cdb_tag_d   = op_tag_q;
          cdb_valid_d = 1'b1;
          state_d     = ST_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WB: begin
        if (cdb_ack) begin
          cdb_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides every state; the RR pointer is deliberately kept.
    if (flush) begin
      state_d     = ST_IDLE;
      cdb_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_RS - 1);
      cnt_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // NOTE: operand holding registers carry no reset; they are only observed
  // after a grant has loaded them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (grant_ok) begin
      op_a_q   <= rs_a[int'(arb_idx)*FLOAT_W +: FLOAT_W];
      op_b_q   <= rs_b[int'(arb_idx)*FLOAT_W +: FLOAT_W];
      op_tag_q <= rs_tag[int'(arb_idx)*TAG_W +: TAG_W];
    end
  end

endmodule
